// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes, one-cycle
// terminal tick, sticky done flag and saturating expiry counter.
module down_timer #(
    parameter int WIDTH  = 5,
    parameter int ECNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              mode,
    input  logic              start,
    input  logic              stop,
    input  logic              clr_done,
    output logic [WIDTH-1:0]  count,
    output logic              tick,
    output logic              busy,
    output logic              done,
    output logic [ECNT_W-1:0] exp_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ECNT_W-1:0] ECNT_MAX = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_rld;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    w_count_nxt;
    logic [WIDTH-1:0]    w_reload;
    logic                r_mode_q;
    logic                w_mode_nxt;
    logic                r_tick;
    logic                w_tick_nxt;
    logic                w_done_set;
    logic                r_done;
    logic                w_done_nxt;
    logic [ECNT_W-1:0]   r_exp_cnt;
    logic [ECNT_W-1:0]   w_exp_cnt_nxt;

    // A load in the same cycle as start/reload takes effect immediately.
    assign w_reload = load ? load_val : r_rld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode_q;
        w_tick_nxt  = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_count_nxt = w_reload;
                    w_mode_nxt  = mode;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // stop wins over terminal count: no tick, count frozen
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (en) begin
                    if (r_count != '0) begin
                        w_count_nxt = r_count - 1'b1;
                    end else begin
                        w_tick_nxt = 1'b1;
                        if (r_mode_q) begin
                            w_count_nxt = w_reload;
                        end else begin
                            w_done_set  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Set dominates clear so an expiry coinciding with clr_done is not lost.
    always_comb begin
        w_done_nxt = w_done_set | (r_done & ~clr_done);
        if (clr_done) begin
            w_exp_cnt_nxt = ECNT_W'(w_tick_nxt);
        end else if (w_tick_nxt && (r_exp_cnt != ECNT_MAX)) begin
            w_exp_cnt_nxt = r_exp_cnt + 1'b1;
        end else begin
            w_exp_cnt_nxt = r_exp_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rld     <= '0;
            r_count   <= '0;
            r_mode_q  <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_exp_cnt <= '0;
        end else begin
            if (load) begin
                r_rld <= load_val;
            end
            r_count   <= w_count_nxt;
            r_mode_q  <= w_mode_nxt;
            r_tick    <= w_tick_nxt;
            r_done    <= w_done_nxt;
            r_exp_cnt <= w_exp_cnt_nxt;
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign busy    = (r_state == S_RUN);
    assign done    = r_done;
    assign exp_cnt = r_exp_cnt;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences for periods, gating, saturation and reset.
module tb_down_timer;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [4:0] load_val;
    logic       mode;
    logic       start;
    logic       stop;
    logic       clr_done;
    logic [4:0] count;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] exp_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    down_timer #(.WIDTH(5), .ECNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .clr_done (clr_done),
        .count    (count),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .exp_cnt  (exp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [4:0] lv;
        logic       md;
        logic       st;
        logic       sp;
        logic       e;
        logic       clr;
        logic [4:0] x_cnt;
        logic       x_tick;
        logic       x_busy;
        logic       x_done;
        logic [7:0] x_exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ld, input logic [4:0] lv, input logic md,
                       input logic st, input logic sp, input logic e, input logic clr,
                       input logic [4:0] xc, input logic xt, input logic xb,
                       input logic xd, input logic [7:0] xe);
        vec_t v;
        v.ld = ld; v.lv = lv; v.md = md; v.st = st; v.sp = sp; v.e = e; v.clr = clr;
        v.x_cnt = xc; v.x_tick = xt; v.x_busy = xb; v.x_done = xd; v.x_exp = xe;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic drive(input logic ld, input logic [4:0] lv, input logic md,
                         input logic st, input logic sp, input logic e, input logic clr);
        load = ld; load_val = lv; mode = md; start = st; stop = sp; en = e; clr_done = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [4:0] xc, input logic xt,
                              input logic xb, input logic xd, input logic [7:0] xe);
        chk({tag, ".count"},   count,   xc);
        chk({tag, ".tick"},    tick,    xt);
        chk({tag, ".busy"},    busy,    xb);
        chk({tag, ".done"},    done,    xd);
        chk({tag, ".exp_cnt"}, exp_cnt, xe);
    endtask

    initial begin
        int nt;
        // ld lv md st sp en clr | count tick busy done exp
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0,  5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  4, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,  5, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,  5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  4, 0, 1, 0, 0);
        add(1, 9, 0, 0, 0, 1, 0,  3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0,  1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 3);
        add(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);

        // Reset held with busy inputs
        reset = 1'b0;
        drive(1, 17, 1, 1, 0, 1, 0);
        #1;
        expect_all("rst_async", 0, 0, 0, 0, 0);
        step();
        step();
        expect_all("rst_clocked", 0, 0, 0, 0, 0);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        expect_all("rst_release", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].ld, tbl[i].lv, tbl[i].md, tbl[i].st, tbl[i].sp, tbl[i].e, tbl[i].clr);
            step();
            expect_all($sformatf("vec%0d", i), tbl[i].x_cnt, tbl[i].x_tick,
                       tbl[i].x_busy, tbl[i].x_done, tbl[i].x_exp);
        end

        // Auto-reload, reload 3: period 4, then reload changed to 1 mid-run
        drive(1, 3, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 0, 0, 0); step();
        chk("auto3.start_count", count, 3);
        nt = 0;
        for (int i = 1; i <= 20; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); step();
            if (tick) nt++;
            chk($sformatf("auto3.tick%0d", i), tick, (i % 4 == 0));
            chk($sformatf("auto3.count%0d", i), count, (i % 4 == 0) ? 3 : 3 - (i % 4));
        end
        chk("auto3.nticks", nt, 5);
        chk("auto3.exp_cnt", exp_cnt, 5);
        chk("auto3.done", done, 0);
        for (int i = 21; i <= 28; i++) begin
            drive(i == 21, 1, 0, 0, 0, 1, 0); step();
            chk($sformatf("auto1.tick%0d", i), tick, (i == 24 || i == 26 || i == 28));
            chk($sformatf("auto1.count%0d", i), count,
                (i < 24) ? 23 - i : ((i % 2 == 0) ? 1 : 0));
        end
        chk("auto1.exp_cnt", exp_cnt, 8);
        drive(0, 0, 0, 0, 1, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1); step();

        // Enable gating, reload 4
        drive(1, 4, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0); step();
        chk("gate.count_before", count, 2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0); step();
            expect_all($sformatf("gate.frozen%0d", i), 2, 0, 1, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0); step();
        expect_all("gate.at0", 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0); step();
        expect_all("gate.tick", 4, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1); step();

        // Reload 31: period 32
        drive(1, 31, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 0, 0, 0); step();
        nt = 0;
        for (int i = 1; i <= 64; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); step();
            if (tick) nt++;
            if (i % 32 == 0) chk($sformatf("p32.tick%0d", i), tick, 1);
        end
        chk("p32.nticks", nt, 2);
        chk("p32.count", count, 31);
        drive(0, 0, 0, 0, 1, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1); step();

        // 300 ticks: exp_cnt saturates
        drive(1, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 0, 0, 0); step();
        for (int i = 1; i <= 300; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); step();
            if (i == 254) chk("sat.exp254", exp_cnt, 254);
            if (i == 255) chk("sat.exp255", exp_cnt, 255);
        end
        chk("sat.exp_final", exp_cnt, 255);
        drive(0, 0, 0, 0, 1, 1, 0); step();

        // Asynchronous reset mid-run at count 7
        drive(1, 9, 0, 1, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0); step();
        expect_all("arst.before", 7, 0, 1, 0, 255);
        #2;
        reset = 1'b0;
        #1;
        expect_all("arst.immediate", 0, 0, 0, 0, 0);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        expect_all("arst.release", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 0); step();
        expect_all("arst.start", 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0); step();
        expect_all("arst.tick", 0, 1, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer with a programmable reload value, one-shot and auto-reload modes, and a one-cycle terminal tick. It is the count-down counterpart of the free-running up-counter/prescaler compare block. It provides periodic or single delays to downstream control logic. A sticky done flag and a saturating expiry counter let slower logic observe events it could otherwise miss.

## Interface
- WIDTH, 5, bit width of the counter and reload value
- ECNT_W, 8, width of the expiry event counter

- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low; clock clk
- en  in  1  count enable; when low, counter and state are frozen
- load  in  1  write strobe for reload register
- load_val  in  WIDTH  reload value written on load
- mode  in  1  0 = one-shot, 1 = auto-reload; sampled on start
- start  in  1  begin counting from reload value (IDLE only)
- stop  in  1  abort counting, return to IDLE
- clr_done  in  1  clear done and exp_cnt
- count  out  WIDTH  current counter value
- tick  out  1  one-cycle pulse on terminal count
- busy  out  1  high while in RUN
- done  out  1  sticky, set on one-shot expiry
- exp_cnt  out  ECNT_W  number of ticks since last clear, saturating

## Operation
- Reset (reset=0): rld=0, count=0, state=IDLE, mode_q=0, tick=0, done=0, exp_cnt=0, busy=0.
- Reload register rld: written when load=1, in any state.
- States:
  - IDLE
  - RUN
- IDLE:
  - start=1 and stop=0 → count ← load_val if load=1 in the same cycle, else rld; mode_q ← mode; go to RUN.
  - en is not required for start.
- RUN, en=1:
  - count≠0 → count ← count−1.
  - count=0 → tick pulses.
    - mode_q=1: count ← reload value (load_val if load=1 in the same cycle, else rld); stay in RUN.
    - mode_q=0: count stays 0; done ← 1; go to IDLE.
- RUN, en=0: count, state and mode_q held; no tick.
- stop=1 in RUN → IDLE next cycle; count holds its current value; no tick that cycle, even if count=0 and en=1.
- stop has priority over start and over terminal count.
- start while in RUN is ignored; no restart.
- Period in auto-reload mode = rld+1 enabled cycles. rld=0 gives a tick on every enabled cycle.
- load_val=0 with start in one-shot mode: tick on the first enabled RUN cycle.
- Arithmetic is unsigned modulo 2^WIDTH. count never underflows, because reload or stop occurs at 0.
- done:
  - Set on one-shot expiry; cleared by clr_done.
  - Set and clear in the same cycle → done=1.
  - Not set in auto-reload mode.
- exp_cnt:
  - +1 per tick; saturates at 2^ECNT_W−1.
  - clr_done → 0; if a tick occurs in the same cycle → 1.
- busy = (state==RUN), combinational from the state register.
- Reset asserted mid-count: all outputs return to their reset values immediately (asynchronous); rld is lost.

## Timing
- All outputs registered except busy, which is decoded directly from the state flop.
- Start latency: start sampled at edge N → busy=1 and count=reload value after edge N. First decrement at edge N+1 if en=1.
- Terminal count: count=0 and en=1 sampled at edge M → tick=1 for the cycle after M only; count reloaded (auto) or busy=0 and done=1 (one-shot) after M.
- One-shot with reload value R and en held high: tick asserted R+1 cycles after the start edge.
- load takes effect for the next start or reload. It never alters count in flight.
- clr_done and done/exp_cnt updates take effect at the sampling edge.

## Test plan
- Reset: reset=0 with any inputs → count=0, tick=0, busy=0, done=0, exp_cnt=0. Release reset → all outputs hold until start.
- One-shot: load 5, mode=0, start, en=1 → count 5,4,3,2,1,0; tick 6 cycles after start; busy drops with tick; done=1 and exp_cnt=1.
- Auto-reload: load 3, mode=1, start, en=1 for 20 cycles → tick every 4 cycles, 5 ticks, exp_cnt=5, done=0. Load 1 mid-run → ticks every 2 cycles after the next reload.
- Enable gating and stop:
  - Auto-reload, rld=4: en=0 for 3 cycles at count=2 → count frozen at 2, no tick.
  - stop at count=1 with en=1 → IDLE, count=1, no tick.
  - start+stop in the same cycle from IDLE → stays IDLE.
- Boundaries:
  - rld=0, auto-reload → tick every enabled cycle.
  - rld=31, WIDTH=5 → period 32.
  - clr_done on the tick cycle → done=1, exp_cnt=1.
  - 300 ticks with ECNT_W=8 → exp_cnt=255.
- Async reset mid-run: reset=0 between edges at count=7 → outputs clear immediately. After release, start with rld=0 (cleared by reset) → tick on the first enabled cycle.
